button_rx: RTL and testbench

Debounced push-button receiver that turns the board's raw user button into classified press events. It is the input-side counterpart to the LED pattern outputs: it synchronises and debounces the button, times each press, and classifies it as short or long. Events are queued in a 4-entry FIFO and offered to downstream logic over a valid/ready handshake.

---
 rtl/button_rx_if.sv | 28 ++
 rtl/button_rx.sv | 155 +++++++++++++++
 tb/tb_button_rx.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/button_rx_if.sv
// ============================================================================
//  Module      : button_rx_if
//  Description : Event handshake between the button receiver (master) and
//                its downstream consumer (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface button_rx_if;
    logic       o_evt_valid;
    logic [1:0] o_evt_code;
    logic       i_evt_ready;

    modport master (
        output o_evt_valid,
        output o_evt_code,
        input  i_evt_ready
    );

    modport slave (
        input  o_evt_valid,
        input  o_evt_code,
        output i_evt_ready
    );
endinterface

`default_nettype wire

// File: rtl/button_rx.sv
// ============================================================================
//  Module      : button_rx
//  Description : Debounced push-button receiver. Synchronises the raw pin,
//                debounces it, times each press and queues short/long press
//                events in a 4-entry FIFO behind a valid/ready handshake.
//                Optional macro BUTTON_RX_LONG_EN enables the hold timer and
//                long-press classification; without it every press is short.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module button_rx #(
    parameter int DEBOUNCE_CYCLES = 240_000,
    parameter int LONG_CYCLES     = 24_000_000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  wire logic       i_clk,
    input  wire logic       i_rst_n,
    input  wire logic       i_btn,
    output logic            o_pressed,
    button_rx_if.master     evt,
    output logic            o_overflow
);

    localparam int         c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [1:0] c_SHORT   = 2'b01;
    localparam logic [2:0] c_DEPTH   = 3'd4;

    // Synchroniser and debouncer state
    logic [1:0]        r_sync;
    logic              r_st;
    logic              r_st_d;
    logic [c_DB_W-1:0] r_db;

    // Event FIFO state
    logic [1:0]        r_mem [4];
    logic [1:0]        r_wr_ptr;
    logic [1:0]        r_rd_ptr;
    logic [2:0]        r_count;
    logic              r_overflow;

    logic              w_sample;
    logic              w_rise;
    logic              w_fall;
    logic [1:0]        w_code;
    logic              w_valid;
    logic              w_full;
    logic              w_pop;
    logic              w_write;
    logic              w_drop;

    // Two-flop synchroniser, parked at the released pin level
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= {2{ACTIVE_LOW}};
        end else begin
            r_sync <= {r_sync[0], i_btn};
        end
    end

    // Normalise so that 1 always means pressed
    assign w_sample = r_sync[1] ^ ACTIVE_LOW;

    // Debouncer: accept a new level only after it has differed long enough
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_st <= 1'b0;
            r_db <= '0;
        end else if (w_sample == r_st) begin
            r_db <= '0;
        end else if (r_db == c_DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_st <= ~r_st;
            r_db <= '0;
        end else begin
            r_db <= r_db + c_DB_W'(1);
        end
    end

    // Delayed stable level for edge detection
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_st_d <= 1'b0;
        end else begin
            r_st_d <= r_st;
        end
    end

    assign w_rise = r_st & ~r_st_d;
    assign w_fall = ~r_st & r_st_d;

`ifdef BUTTON_RX_LONG_EN
    localparam int c_HOLD_W = $clog2(LONG_CYCLES + 1);
    logic [c_HOLD_W-1:0] r_hold;

    // Hold timer: restarts on press, saturates so long holds never wrap
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_hold <= '0;
        end else if (w_rise) begin
            r_hold <= '0;
        end else if (r_st && (r_hold != c_HOLD_W'(LONG_CYCLES))) begin
            r_hold <= r_hold + c_HOLD_W'(1);
        end
    end

    assign w_code = (r_hold >= c_HOLD_W'(LONG_CYCLES)) ? 2'b10 : c_SHORT;
`else
    assign w_code = c_SHORT;
`endif

    // FIFO control; a full FIFO still accepts a push when the head leaves
    assign w_valid = (r_count != 3'd0);
    assign w_full  = (r_count == c_DEPTH);
    assign w_pop   = w_valid & evt.i_evt_ready;
    assign w_write = w_fall & (~w_full | w_pop);
    assign w_drop  = w_fall & w_full & ~w_pop;

    // FIFO storage, pointers, occupancy and sticky overflow flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_mem[i] <= 2'b00;
            end
            r_wr_ptr   <= 2'd0;
            r_rd_ptr   <= 2'd0;
            r_count    <= 3'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_write) begin
                r_mem[r_wr_ptr] <= w_code;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 2'd1;
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + 3'd1;
                2'b01:   r_count <= r_count - 3'd1;
                default: r_count <= r_count;
            endcase
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_pressed       = r_st;
    assign o_overflow      = r_overflow;
    assign evt.o_evt_valid = w_valid;
    assign evt.o_evt_code  = w_valid ? r_mem[r_rd_ptr] : 2'b00;

endmodule

`default_nettype wire

// File: tb/tb_button_rx.sv
// ============================================================================
//  Module      : tb_button_rx
//  Description : Directed self-checking bench for button_rx with
//                DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_button_rx;

    localparam int c_DB   = 4;
    localparam int c_LONG = 20;
`ifdef BUTTON_RX_LONG_EN
    localparam logic [1:0] c_LONG_CODE = 2'b10;
`else
    localparam logic [1:0] c_LONG_CODE = 2'b01;
`endif

    logic clk      = 1'b0;
    logic rst_n    = 1'b0;
    logic btn      = 1'b1;
    logic pressed;
    logic overflow;

    int checks   = 0;
    int failures = 0;

    button_rx_if u_if ();

    button_rx #(
        .DEBOUNCE_CYCLES (c_DB),
        .LONG_CYCLES     (c_LONG),
        .ACTIVE_LOW      (1'b1)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_btn      (btn),
        .o_pressed  (pressed),
        .evt        (u_if),
        .o_overflow (overflow)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One press: low for n_low cycles, then high for n_high cycles
    task automatic press(input int n_low, input int n_high);
        btn = 1'b0;
        step(n_low);
        btn = 1'b1;
        step(n_high);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        btn = 1'b1;
        u_if.i_evt_ready = 1'b1;
        step(3);
        checks++;
        if (pressed !== 1'b0) begin failures++; $display("FAIL reset_pressed: got %b expected 0", pressed); end
        checks++;
        if (u_if.o_evt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", u_if.o_evt_valid); end
        checks++;
        if (u_if.o_evt_code !== 2'b00) begin failures++; $display("FAIL reset_code: got %b expected 00", u_if.o_evt_code); end
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_short_press;
        int nv;
        logic [1:0] code;
        btn = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            if (k == 5) begin
                checks++;
                if (pressed !== 1'b0) begin failures++; $display("FAIL short_rise_early: got %b expected 0", pressed); end
            end
            if (k == 6) begin
                checks++;
                if (pressed !== 1'b1) begin failures++; $display("FAIL short_rise: got %b expected 1", pressed); end
            end
        end
        btn = 1'b1;
        nv = 0;
        code = 2'b00;
        for (int j = 1; j <= 12; j++) begin
            step(1);
            if (j == 5) begin
                checks++;
                if (pressed !== 1'b1) begin failures++; $display("FAIL short_fall_early: got %b expected 1", pressed); end
            end
            if (j == 6) begin
                checks++;
                if (pressed !== 1'b0 || u_if.o_evt_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL short_fall: got pressed=%b valid=%b expected pressed=0 valid=0", pressed, u_if.o_evt_valid);
                end
            end
            if (j == 7) begin
                checks++;
                if (u_if.o_evt_valid !== 1'b1) begin failures++; $display("FAIL short_valid_latency: got %b expected 1", u_if.o_evt_valid); end
            end
            if (j == 8) begin
                checks++;
                if (u_if.o_evt_code !== 2'b00) begin failures++; $display("FAIL short_idle_code: got %b expected 00", u_if.o_evt_code); end
            end
            if (u_if.o_evt_valid === 1'b1) begin
                nv++;
                code = u_if.o_evt_code;
            end
        end
        checks++;
        if (nv != 1) begin failures++; $display("FAIL short_event_count: got %0d expected 1", nv); end
        checks++;
        if (code !== 2'b01) begin failures++; $display("FAIL short_code: got %b expected 01", code); end
    endtask

    task automatic test_bounce;
        int total;
        int len;
        total = 0;
        for (int i = 0; total < 40; i++) begin
            len = (i % 3) + 1;
            if (total + len > 40) len = 40 - total;
            btn = (i % 2 == 0) ? 1'b0 : 1'b1;
            for (int c = 0; c < len; c++) begin
                step(1);
                checks++;
                if (pressed !== 1'b0 || u_if.o_evt_valid !== 1'b0 || overflow !== 1'b0) begin
                    failures++;
                    $display("FAIL bounce: got pressed=%b valid=%b overflow=%b expected all 0", pressed, u_if.o_evt_valid, overflow);
                end
            end
            total += len;
        end
        btn = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step(1);
            checks++;
            if (pressed !== 1'b0 || u_if.o_evt_valid !== 1'b0 || overflow !== 1'b0) begin
                failures++;
                $display("FAIL bounce_tail: got pressed=%b valid=%b overflow=%b expected all 0", pressed, u_if.o_evt_valid, overflow);
            end
        end
    endtask

    task automatic test_long_press;
        int nv;
        logic [1:0] code;
        btn = 1'b0;
        step(30);
        checks++;
        if (pressed !== 1'b1) begin failures++; $display("FAIL long_held: got %b expected 1", pressed); end
        btn = 1'b1;
        nv = 0;
        code = 2'b00;
        for (int j = 1; j <= 12; j++) begin
            step(1);
            if (u_if.o_evt_valid === 1'b1) begin
                nv++;
                code = u_if.o_evt_code;
            end
        end
        checks++;
        if (nv != 1) begin failures++; $display("FAIL long_event_count: got %0d expected 1", nv); end
        checks++;
        if (code !== c_LONG_CODE) begin failures++; $display("FAIL long_code: got %b expected %b", code, c_LONG_CODE); end
    endtask

    task automatic test_full_push_pop;
        logic [1:0] exp [4];
        exp[0] = 2'b01;
        exp[1] = 2'b01;
        exp[2] = 2'b01;
        exp[3] = c_LONG_CODE;
        u_if.i_evt_ready = 1'b0;
        for (int p = 0; p < 4; p++) press(10, 10);
        checks++;
        if (u_if.o_evt_valid !== 1'b1 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fpp_filled: got valid=%b overflow=%b expected valid=1 overflow=0", u_if.o_evt_valid, overflow);
        end
        btn = 1'b0;
        step(30);
        btn = 1'b1;
        step(6);
        u_if.i_evt_ready = 1'b1;
        step(1);
        u_if.i_evt_ready = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL fpp_overflow: got %b expected 0", overflow); end
        step(3);
        u_if.i_evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i < 4) begin
                if (u_if.o_evt_valid !== 1'b1 || u_if.o_evt_code !== exp[i]) begin
                    failures++;
                    $display("FAIL fpp_drain[%0d]: got valid=%b code=%b expected valid=1 code=%b", i, u_if.o_evt_valid, u_if.o_evt_code, exp[i]);
                end
            end else begin
                if (u_if.o_evt_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL fpp_drain_empty[%0d]: got valid=%b expected 0", i, u_if.o_evt_valid);
                end
            end
            step(1);
        end
    endtask

    task automatic test_overflow;
        u_if.i_evt_ready = 1'b0;
        press(10, 10);
        checks++;
        if (u_if.o_evt_valid !== 1'b1 || u_if.o_evt_code !== 2'b01) begin
            failures++;
            $display("FAIL ovf_first: got valid=%b code=%b expected valid=1 code=01", u_if.o_evt_valid, u_if.o_evt_code);
        end
        for (int p = 0; p < 3; p++) press(10, 10);
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_fourth: got %b expected 0", overflow); end
        press(10, 10);
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_fifth: got %b expected 1", overflow); end
        u_if.i_evt_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i < 4) begin
                if (u_if.o_evt_valid !== 1'b1 || u_if.o_evt_code !== 2'b01) begin
                    failures++;
                    $display("FAIL ovf_drain[%0d]: got valid=%b code=%b expected valid=1 code=01", i, u_if.o_evt_valid, u_if.o_evt_code);
                end
            end else begin
                if (u_if.o_evt_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL ovf_drain_empty[%0d]: got valid=%b expected 0", i, u_if.o_evt_valid);
                end
            end
            step(1);
        end
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_reset_mid_hold;
        int nv;
        logic [1:0] code;
        btn = 1'b0;
        step(15);
        rst_n = 1'b0;
        step(1);
        checks++;
        if (pressed !== 1'b0 || u_if.o_evt_valid !== 1'b0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL rmh_in_reset: got pressed=%b valid=%b overflow=%b expected all 0", pressed, u_if.o_evt_valid, overflow);
        end
        step(1);
        rst_n = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            step(1);
            if (k == 5) begin
                checks++;
                if (pressed !== 1'b0) begin failures++; $display("FAIL rmh_redetect_early: got %b expected 0", pressed); end
            end
            if (k == 6) begin
                checks++;
                if (pressed !== 1'b1) begin failures++; $display("FAIL rmh_redetect: got %b expected 1", pressed); end
            end
            checks++;
            if (u_if.o_evt_valid !== 1'b0) begin failures++; $display("FAIL rmh_no_event[%0d]: got %b expected 0", k, u_if.o_evt_valid); end
        end
        btn = 1'b1;
        nv = 0;
        code = 2'b00;
        for (int j = 1; j <= 12; j++) begin
            step(1);
            if (u_if.o_evt_valid === 1'b1) begin
                nv++;
                code = u_if.o_evt_code;
            end
        end
        checks++;
        if (nv != 1) begin failures++; $display("FAIL rmh_event_count: got %0d expected 1", nv); end
        checks++;
        if (code !== c_LONG_CODE) begin failures++; $display("FAIL rmh_code: got %b expected %b", code, c_LONG_CODE); end
    endtask

    initial begin
        u_if.i_evt_ready = 1'b1;
        test_reset();
        test_short_press();
        test_bounce();
        test_long_press();
        test_full_push_pop();
        test_overflow();
        test_reset_mid_hold();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
